// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to mem, then starts the CPU.
// Optional build macro CHECKSUM_EN adds a trailing checksum word verified against the sum of DATA words.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] CAPACITY  = 16'hffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        write,
  output logic        read,
  output logic        INT,
  output logic [31:0] entryPoint,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR_E = 4'd1,
    S_HDR_N = 4'd2,
    S_DATA  = 4'd3,
    S_WR    = 4'd4,
`ifdef CHECKSUM_EN
    S_CSUM  = 4'd8,
`endif
    S_START = 4'd5,
    S_DONE  = 4'd6,
    S_ERR   = 4'd7
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_START;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] n_q, n_d;
  logic [31:0] address_q, address_d;
  logic [31:0] mem_in_q, mem_in_d;
  logic [31:0] entry_q, entry_d;
  logic        in_ready_q, in_ready_d;
  logic        write_q, write_d;
  logic        int_q, int_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
`ifdef CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        xfer_s;
  logic        last_byte_s;
  logic [31:0] full_word_s;

  assign xfer_s      = in_valid & in_ready_q;
  assign last_byte_s = xfer_s & (cnt_q == 2'd3);
  assign full_word_s = {in_data, word_q};

  // Next-state, byte assembly and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    n_d       = n_q;
    address_d = address_q;
    mem_in_d  = mem_in_q;
    entry_d   = entry_q;
    err_d     = err_q;
`ifdef CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (xfer_s) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    word_d[7:0]   = in_data;
        2'd1:    word_d[15:8]  = in_data;
        2'd2:    word_d[23:16] = in_data;
        default: word_d        = word_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (xfer_s) state_d = S_HDR_E;
        else        state_d = S_IDLE;
      end
      S_HDR_E: begin
        if (last_byte_s) begin
          entry_d = full_word_s;
          state_d = S_HDR_N;
        end else begin
          state_d = S_HDR_E;
        end
      end
      S_HDR_N: begin
        if (last_byte_s) begin
          n_d     = full_word_s;
          state_d = (full_word_s == 32'd0) ? S_TAIL : S_DATA;
        end else begin
          state_d = S_HDR_N;
        end
      end
      S_DATA: begin
        // Bounds are checked before the write is committed, so an overflow never reaches mem
        if (last_byte_s) begin
          if (address_q > {16'h0000, CAPACITY}) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            mem_in_d = full_word_s;
`ifdef CHECKSUM_EN
            sum_d    = sum_q + full_word_s;
`endif
            state_d  = S_WR;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WR: begin
        address_d = address_q + 32'd4;
        n_d       = n_q - 32'd1;
        state_d   = (n_q == 32'd1) ? S_TAIL : S_DATA;
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (last_byte_s) begin
          if (full_word_s == sum_q) begin
            state_d = S_START;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_START: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_HDR_E) ||
                 (state_d == S_HDR_N) || (state_d == S_DATA);
`ifdef CHECKSUM_EN
    in_ready_d = in_ready_d || (state_d == S_CSUM);
`endif
    write_d = (state_d == S_WR);
    int_d   = (state_d == S_START);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      word_q     <= 24'd0;
      n_q        <= 32'd0;
      address_q  <= BASE_ADDR;
      mem_in_q   <= 32'd0;
      entry_q    <= 32'd0;
      in_ready_q <= 1'b0;
      write_q    <= 1'b0;
      int_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      n_q        <= n_d;
      address_q  <= address_d;
      mem_in_q   <= mem_in_d;
      entry_q    <= entry_d;
      in_ready_q <= in_ready_d;
      write_q    <= write_d;
      int_q      <= int_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign address    = address_q;
  assign memIn      = mem_in_q;
  assign write      = write_q;
  assign read       = 1'b0;
  assign INT        = int_q;
  assign entryPoint = entry_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
